// File: rtl/score_pkg.sv
// Shared definitions for the drift score range-match pulse generator.
//   MODE_PERIODIC / MODE_ONESHOT : per-channel mode encoding
//   CNT_W_DEF / SCORE_W_DEF      : default counter and score widths
package score_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int unsigned CNT_W_DEF   = 10;
  localparam int unsigned SCORE_W_DEF = 16;

endpackage

// File: rtl/score_channel.sv
// One range-match scoring channel: free counter compared against a
// programmable match value, one-cycle registered pulse on match, sticky
// one-shot done flag and a saturating pulse-count score.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   enable          : count enable (hold when low)
//   clear           : synchronous clear of counter, done and score
//   mode            : 0 = periodic reload, 1 = one-shot
//   match_val       : compare value
//   pulse           : registered one-cycle match pulse
//   done            : one-shot completed, sticky until clear/reset
//   score           : saturating number of pulses issued
module score_channel
  import score_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned SCORE_W = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic               mode,
  input  logic [CNT_W-1:0]   match_val,
  output logic               pulse,
  output logic               done,
  output logic [SCORE_W-1:0] score
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               done_d;
  logic               pulse_d;
  logic [SCORE_W-1:0] score_d;

  // Next-state: clear > match > count > hold.
  always_comb begin
    cnt_d   = cnt_q;
    done_d  = done;
    score_d = score;
    pulse_d = 1'b0;
    if (clear) begin
      cnt_d   = '0;
      done_d  = 1'b0;
      score_d = '0;
    end else if (enable && !done) begin
      if (cnt_q == match_val) begin
        pulse_d = 1'b1;
        if (score != SCORE_MAX) begin
          score_d = score + SCORE_W'(1);
        end
        // One-shot parks the counter on the match value.
        if (mode == MODE_ONESHOT) begin
          done_d = 1'b1;
        end else begin
          cnt_d = '0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State register; reset dominates everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      done  <= 1'b0;
      score <= '0;
      pulse <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      done  <= done_d;
      score <= score_d;
      pulse <= pulse_d;
    end
  end

endmodule

// File: rtl/score_pulse_gen_multi.sv
// Multi-channel range-match pulse generator and scorer. N_CH independent
// score_channel instances; buses are sliced per channel.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_enable       : per-channel count enable
//   i_clear        : per-channel clear of counter, done and score
//   i_mode         : per-channel mode (0 periodic, 1 one-shot)
//   i_range        : channel k match value at [k*CNT_W +: CNT_W]
//   o_pulse        : per-channel registered match pulse
//   o_done         : per-channel sticky one-shot done
//   o_score        : channel k score at [k*SCORE_W +: SCORE_W]
module score_pulse_gen_multi
  import score_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned SCORE_W = SCORE_W_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [N_CH-1:0]         i_enable,
  input  logic [N_CH-1:0]         i_clear,
  input  logic [N_CH-1:0]         i_mode,
  input  logic [N_CH*CNT_W-1:0]   i_range,
  output logic [N_CH-1:0]         o_pulse,
  output logic [N_CH-1:0]         o_done,
  output logic [N_CH*SCORE_W-1:0] o_score
);

  // One fully independent channel per lane.
  for (genvar k = 0; k < int'(N_CH); k++) begin : g_ch
    score_channel #(
      .CNT_W   (CNT_W),
      .SCORE_W (SCORE_W)
    ) u_ch (
      .clk       (i_clk),
      .reset     (i_reset),
      .enable    (i_enable[k]),
      .clear     (i_clear[k]),
      .mode      (i_mode[k]),
      .match_val (i_range[k*CNT_W +: CNT_W]),
      .pulse     (o_pulse[k]),
      .done      (o_done[k]),
      .score     (o_score[k*SCORE_W +: SCORE_W])
    );
  end

endmodule

// File: tb/tb_score_pulse_gen_multi.sv
// Self-checking bench for score_pulse_gen_multi: directed scenarios with
// fixed expected cycle numbers plus randomized traffic against a cycle model.
module tb_score_pulse_gen_multi;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned N_CH    = 4;
  localparam int unsigned SCORE_W = 16;
  localparam int unsigned SW4     = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_CH-1:0]         enable, clear, mode;
  logic [N_CH*CNT_W-1:0]   range;
  logic [N_CH-1:0]         pulse, done, pulse4, done4;
  logic [N_CH*SCORE_W-1:0] score;
  logic [N_CH*SW4-1:0]     score4;

  // Reference state
  int                      m_cnt [N_CH];
  bit                      m_done[N_CH];
  int                      m_sc  [N_CH];
  int                      m_sc4 [N_CH];
  logic [N_CH-1:0]         e_pulse, e_done;
  logic [N_CH*SCORE_W-1:0] e_score;
  logic [N_CH*SW4-1:0]     e_score4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  score_pulse_gen_multi #(.CNT_W(CNT_W), .N_CH(N_CH), .SCORE_W(SCORE_W)) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_clear(clear),
    .i_mode(mode), .i_range(range), .o_pulse(pulse), .o_done(done),
    .o_score(score));

  score_pulse_gen_multi #(.CNT_W(CNT_W), .N_CH(N_CH), .SCORE_W(SW4)) dut4 (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_clear(clear),
    .i_mode(mode), .i_range(range), .o_pulse(pulse4), .o_done(done4),
    .o_score(score4));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one edge and apply the behavioural rules to the model.
  task automatic step();
    int rg;
    @(posedge clk);
    for (int k = 0; k < int'(N_CH); k++) begin
      rg = int'(range[k*CNT_W +: CNT_W]);
      e_pulse[k] = 1'b0;
      if (reset || clear[k]) begin
        m_cnt[k] = 0; m_done[k] = 1'b0; m_sc[k] = 0; m_sc4[k] = 0;
      end else if (enable[k] && !m_done[k]) begin
        if (m_cnt[k] == rg) begin
          e_pulse[k] = 1'b1;
          if (m_sc[k]  < (1 << SCORE_W) - 1) m_sc[k]++;
          if (m_sc4[k] < (1 << SW4) - 1)     m_sc4[k]++;
          if (mode[k]) m_done[k] = 1'b1;
          else         m_cnt[k]  = 0;
        end else begin
          m_cnt[k] = (m_cnt[k] + 1) % (1 << CNT_W);
        end
      end
      e_done[k]                    = m_done[k];
      e_score[k*SCORE_W +: SCORE_W] = SCORE_W'(m_sc[k]);
      e_score4[k*SW4 +: SW4]        = SW4'(m_sc4[k]);
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = '0; clear = '0; mode = '0; range = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic set_range(input int k, input int v);
    range[k*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic test_reset();
    do_reset();
    enable = '1;
    for (int k = 0; k < int'(N_CH); k++) set_range(k, 1);
    repeat (5) step();
    reset = 1'b1;
    clear = N_CH'($urandom);
    step();
    checks++;
    if ({pulse, done, score, pulse4, done4, score4} !== '0) begin
      errors++;
      $display("FAIL reset_state: got p=%b d=%b s=%h s4=%h, required all zero",
               pulse, done, score, score4);
    end
    reset = 1'b0; clear = '0;
  endtask

  task automatic test_periodic();
    logic [N_CH-1:0] ep;
    do_reset();
    set_range(0, 3); set_range(1, 1); set_range(2, 1); set_range(3, 1);
    enable = 4'b0001;
    for (int c = 1; c <= 12; c++) begin
      step();
      ep = (c % 4 == 0) ? 4'b0001 : 4'b0000;
      checks++;
      if (pulse !== ep) begin
        errors++;
        $display("FAIL periodic_pulse c=%0d: got %b, required %b", c, pulse, ep);
      end
      checks++;
      if ({pulse, done, score} !== {e_pulse, e_done, e_score}) begin
        errors++;
        $display("FAIL periodic_model c=%0d: got %h, required %h", c,
                 {pulse, done, score}, {e_pulse, e_done, e_score});
      end
    end
    checks++;
    if (score !== {48'd0, 16'd3}) begin
      errors++;
      $display("FAIL periodic_score: got %h, required ch0=3 others 0", score);
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    set_range(1, 5);
    mode = 4'b0010; enable = 4'b0010;
    for (int c = 1; c <= 26; c++) begin
      step();
      checks++;
      if (pulse[1] !== (c == 6) || done[1] !== (c >= 6) ||
          score[SCORE_W +: SCORE_W] !== SCORE_W'(c >= 6 ? 1 : 0)) begin
        errors++;
        $display("FAIL oneshot c=%0d: got p=%b d=%b s=%0d", c, pulse[1], done[1],
                 score[SCORE_W +: SCORE_W]);
      end
    end
    clear = 4'b0010;
    step();
    clear = '0;
    checks++;
    if (done[1] !== 1'b0 || pulse[1] !== 1'b0 || score[SCORE_W +: SCORE_W] !== '0) begin
      errors++;
      $display("FAIL oneshot_clear: got d=%b p=%b s=%0d, required 0 0 0",
               done[1], pulse[1], score[SCORE_W +: SCORE_W]);
    end
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++;
      if (pulse[1] !== (c == 6) || done[1] !== (c >= 6)) begin
        errors++;
        $display("FAIL oneshot_rearm c=%0d: got p=%b d=%b", c, pulse[1], done[1]);
      end
    end
  endtask

  task automatic test_saturate();
    int es;
    do_reset();
    set_range(0, 0);
    enable = 4'b0001;
    for (int c = 1; c <= 22; c++) begin
      step();
      es = (c > 15) ? 15 : c;
      checks++;
      if (pulse4[0] !== 1'b1 || score4[0 +: SW4] !== SW4'(es)) begin
        errors++;
        $display("FAIL saturate c=%0d: got p=%b s=%0d, required p=1 s=%0d",
                 c, pulse4[0], score4[0 +: SW4], es);
      end
      checks++;
      if ({pulse4, done4, score4} !== {e_pulse, e_done, e_score4}) begin
        errors++;
        $display("FAIL saturate_model c=%0d: got %h, required %h", c,
                 {pulse4, done4, score4}, {e_pulse, e_done, e_score4});
      end
    end
  endtask

  task automatic test_clear_on_match();
    do_reset();
    set_range(2, 2);
    enable = 4'b0100;
    repeat (2) step();
    clear = 4'b0100;
    step();
    clear = '0;
    checks++;
    if (pulse[2] !== 1'b0 || score[2*SCORE_W +: SCORE_W] !== '0) begin
      errors++;
      $display("FAIL clear_on_match: got p=%b s=%0d, required 0 0",
               pulse[2], score[2*SCORE_W +: SCORE_W]);
    end
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if (pulse[2] !== (c == 3)) begin
        errors++;
        $display("FAIL clear_restart c=%0d: got %b, required %b", c, pulse[2], c == 3);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_range(0, 7);
    enable = 4'b0001;
    repeat (20) step();
    checks++;
    if (score[0 +: SCORE_W] !== SCORE_W'(2)) begin
      errors++;
      $display("FAIL reset_mid_pre: got score %0d, required 2", score[0 +: SCORE_W]);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({pulse, done, score} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %h, required 0", {pulse, done, score});
    end
    for (int c = 1; c <= 9; c++) begin
      step();
      checks++;
      if (pulse[0] !== (c == 8)) begin
        errors++;
        $display("FAIL reset_mid_restart c=%0d: got %b, required %b", c, pulse[0], c == 8);
      end
    end
  endtask

  task automatic test_independence();
    do_reset();
    set_range(0, 2); set_range(3, 6);
    for (int c = 1; c <= 14; c++) begin
      enable = {!(c >= 3 && c <= 5), 2'b00, 1'b1};
      step();
      checks++;
      if (pulse[0] !== (c % 3 == 0) || pulse[3] !== (c == 10)) begin
        errors++;
        $display("FAIL independence c=%0d: got ch0=%b ch3=%b, required %b %b",
                 c, pulse[0], pulse[3], c % 3 == 0, c == 10);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < int'(N_CH); k++) begin
        enable[k] = ($urandom_range(0, 9) != 0);
        clear[k]  = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 29) == 0) mode[k] = 1'($urandom);
        if ($urandom_range(0, 24) == 0) set_range(k, int'($urandom_range(0, 12)));
      end
      step();
      checks++;
      if ({pulse, done, score, pulse4, done4, score4} !==
          {e_pulse, e_done, e_score, e_pulse, e_done, e_score4}) begin
        errors++;
        $display("FAIL random c=%0d: got p=%b d=%b s=%h s4=%h, required p=%b d=%b s=%h s4=%h",
                 c, pulse, done, score, score4, e_pulse, e_done, e_score, e_score4);
      end
    end
    reset = 1'b0; clear = '0;
  endtask

  initial begin
    reset = 1'b1; enable = '0; clear = '0; mode = '0; range = '0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_saturate();
    test_clear_on_match();
    test_reset_mid();
    test_independence();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
